// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan code to ASCII decoder with make/break, E0, Shift and Caps
// tracking, feeding a small first-word-fall-through FIFO polled by the CPU.
module ps2_key_decoder #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_data,
  input  logic       ps2_ready,
  output logic       ps2_rdn,
  input  logic       key_rd,
  output logic [7:0] key_dout,
  output logic       key_ready,
  output logic       key_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    DECODE = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [7:0] byte_r;
  logic       brk, ext, shift, caps;

  logic       push;
  logic [7:0] push_char;
  logic [7:0] letter_lc;
  logic [15:0] digit_pair;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          empty, full, pop, wr_en;

  // Lowercase ASCII for a letter make code, 0 when the code is not a letter.
  function automatic logic [7:0] letter_of(input logic [7:0] code);
    logic [7:0] ch;
    case (code)
      8'h1C: ch = "a";  8'h32: ch = "b";  8'h21: ch = "c";  8'h23: ch = "d";
      8'h24: ch = "e";  8'h2B: ch = "f";  8'h34: ch = "g";  8'h33: ch = "h";
      8'h43: ch = "i";  8'h3B: ch = "j";  8'h42: ch = "k";  8'h4B: ch = "l";
      8'h3A: ch = "m";  8'h31: ch = "n";  8'h44: ch = "o";  8'h4D: ch = "p";
      8'h15: ch = "q";  8'h2D: ch = "r";  8'h1B: ch = "s";  8'h2C: ch = "t";
      8'h3C: ch = "u";  8'h2A: ch = "v";  8'h1D: ch = "w";  8'h22: ch = "x";
      8'h35: ch = "y";  8'h1A: ch = "z";
      default: ch = 8'h00;
    endcase
    return ch;
  endfunction

  // {shifted, plain} ASCII for a digit-row make code, 0 when not a digit key.
  function automatic logic [15:0] digit_of(input logic [7:0] code);
    logic [15:0] pair;
    case (code)
      8'h16: pair = {"!", "1"};
      8'h1E: pair = {"@", "2"};
      8'h26: pair = {"#", "3"};
      8'h25: pair = {"$", "4"};
      8'h2E: pair = {"%", "5"};
      8'h36: pair = {"^", "6"};
      8'h3D: pair = {"&", "7"};
      8'h3E: pair = {"*", "8"};
      8'h46: pair = {"(", "9"};
      8'h45: pair = {")", "0"};
      default: pair = 16'h0000;
    endcase
    return pair;
  endfunction

  assign letter_lc  = letter_of(byte_r);
  assign digit_pair = digit_of(byte_r);

  // State register; ps2_rdn is registered from the next state so it is low
  // for exactly the cycle the FSM sits in POP.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (rst) begin
      state   <= IDLE;
      ps2_rdn <= 1'b1;
    end else begin
      state   <= state_next;
      ps2_rdn <= (state_next != POP);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ps2_ready) state_next = POP;
      POP:     state_next = DECODE;
      DECODE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: which character, if any, the byte in DECODE produces.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    push      = 1'b0;
    push_char = 8'h00;
    if (state == DECODE && byte_r != SC_BREAK && byte_r != SC_EXT && !brk) begin
      if (ext) begin
        case (byte_r)
          8'h75: begin push = 1'b1; push_char = 8'h80; end
          8'h72: begin push = 1'b1; push_char = 8'h81; end
          8'h6B: begin push = 1'b1; push_char = 8'h82; end
          8'h74: begin push = 1'b1; push_char = 8'h83; end
          default: push = 1'b0;
        endcase
      end else if (letter_lc != 8'h00) begin
        push      = 1'b1;
        push_char = (shift ^ caps) ? (letter_lc - 8'h20) : letter_lc;
      end else if (digit_pair != 16'h0000) begin
        push      = 1'b1;
        push_char = shift ? digit_pair[15:8] : digit_pair[7:0];
      end else begin
        case (byte_r)
          8'h29: begin push = 1'b1; push_char = 8'h20; end
          8'h5A: begin push = 1'b1; push_char = 8'h0D; end
          8'h66: begin push = 1'b1; push_char = 8'h08; end
          8'h76: begin push = 1'b1; push_char = 8'h1B; end
          8'h0D: begin push = 1'b1; push_char = 8'h09; end
          default: push = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_r <= 8'h00;
    end else if (state == IDLE && ps2_ready) begin
      byte_r <= ps2_data;
    end
  end

  // Prefix and modifier tracking; prefixes apply only to the next non-prefix byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      brk   <= 1'b0;
      ext   <= 1'b0;
      shift <= 1'b0;
      caps  <= 1'b0;
    end else if (state == DECODE) begin
      if (byte_r == SC_BREAK) begin
        brk <= 1'b1;
      end else if (byte_r == SC_EXT) begin
        ext <= 1'b1;
      end else begin
        brk <= 1'b0;
        ext <= 1'b0;
        if (byte_r == SC_LSHIFT || byte_r == SC_RSHIFT) shift <= ~brk;
        if (byte_r == SC_CAPS && !brk) caps <= ~caps;
      end
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = key_rd && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO proceeds.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and the read port is forced to 0 while empty.
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_char;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      key_overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) key_overflow <= 1'b1;
    end
  end

  assign key_ready = !empty;
  assign key_dout  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed and randomized bench for ps2_key_decoder against a table-driven
// keyboard/FIFO reference model.
module tb_ps2_key_decoder;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ps2_data;
  logic       ps2_ready;
  logic       ps2_rdn;
  logic       key_rd;
  logic [7:0] key_dout;
  logic       key_ready;
  logic       key_overflow;

  ps2_key_decoder #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_data     (ps2_data),
    .ps2_ready    (ps2_ready),
    .ps2_rdn      (ps2_rdn),
    .key_rd       (key_rd),
    .key_dout     (key_dout),
    .key_ready    (key_ready),
    .key_overflow (key_overflow)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;
  int rdn_lows  = 0;

  always @(negedge clk) if (ps2_rdn === 1'b0) rdn_lows++;

  // Reference model state
  logic [7:0] exp_q[$];
  bit m_brk, m_ext, m_shift, m_caps, m_ovf;

  string      letters = "abcdefghijklmnopqrstuvwxyz";
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                    8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  string      digits   = "1234567890";
  string      shifted  = "!@#$%^&*()";
  logic [7:0] digit_codes [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                                   8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
  logic [7:0] misc_pool [16] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h5A, 8'h66, 8'h76,
                                 8'h0D, 8'h11, 8'h00, 8'hFF, 8'h05, 8'h14, 8'h7C, 8'h83};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_brk = 0; m_ext = 0; m_shift = 0; m_caps = 0; m_ovf = 0;
  endtask

  // Character the keyboard rules assign to byte b given the current modifiers.
  task automatic model_char(input logic [7:0] b, output bit has, output logic [7:0] c);
    has = 0;
    c   = 8'h00;
    if (m_ext) begin
      case (b)
        8'h75: begin has = 1; c = 8'h80; end
        8'h72: begin has = 1; c = 8'h81; end
        8'h6B: begin has = 1; c = 8'h82; end
        8'h74: begin has = 1; c = 8'h83; end
        default: has = 0;
      endcase
    end else begin
      for (int i = 0; i < 26; i++)
        if (letter_codes[i] == b) begin
          has = 1;
          c = (m_shift != m_caps) ? letters[i] - 8'd32 : letters[i];
        end
      for (int i = 0; i < 10; i++)
        if (digit_codes[i] == b) begin
          has = 1;
          c = m_shift ? shifted[i] : digits[i];
        end
      case (b)
        8'h29: begin has = 1; c = 8'h20; end
        8'h5A: begin has = 1; c = 8'h0D; end
        8'h66: begin has = 1; c = 8'h08; end
        8'h76: begin has = 1; c = 8'h1B; end
        8'h0D: begin has = 1; c = 8'h09; end
        default: ;
      endcase
    end
  endtask

  task automatic model_decode(input logic [7:0] b, input bit rd);
    bit         has = 0;
    logic [7:0] c = 8'h00;
    bit         popped, was_full;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else begin
      if (!m_brk) model_char(b, has, c);
      if (b == 8'h12 || b == 8'h59) m_shift = !m_brk;
      if (b == 8'h58 && !m_brk) m_caps = !m_caps;
      m_brk = 0;
      m_ext = 0;
    end
    was_full = (exp_q.size() == DEPTH);
    popped   = rd && (exp_q.size() > 0);
    if (popped) void'(exp_q.pop_front());
    if (has) begin
      if (was_full && !popped) m_ovf = 1;
      else exp_q.push_back(c);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_ready"}, key_ready, exp_q.size() != 0);
    check({tag, "_dout"}, key_dout, (exp_q.size() != 0) ? exp_q[0] : 8'h00);
    check({tag, "_ovf"}, key_overflow, m_ovf);
  endtask

  task automatic check_mods(input string tag);
    check({tag, "_shift"}, dut.shift, m_shift);
    check({tag, "_caps"}, dut.caps, m_caps);
    check({tag, "_brk"}, dut.brk, m_brk);
    check({tag, "_ext"}, dut.ext, m_ext);
  endtask

  // Starts and ends at a negedge; back-to-back calls run at 1 byte per 3 clocks.
  task automatic send_byte(input logic [7:0] b, input bit rd_at_decode = 0);
    ps2_data  = b;
    ps2_ready = 1'b1;
    @(negedge clk);
    ps2_ready = 1'b0;
    ps2_data  = 8'($urandom);
    check($sformatf("rdn_low_%02h", b), ps2_rdn, 1'b0);
    @(negedge clk);
    check($sformatf("rdn_rel_%02h", b), ps2_rdn, 1'b1);
    key_rd = rd_at_decode;
    @(negedge clk);
    key_rd = 1'b0;
    model_decode(b, rd_at_decode);
    check_outputs($sformatf("dec_%02h", b));
  endtask

  task automatic read_key(input string tag);
    key_rd = 1'b1;
    @(negedge clk);
    key_rd = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    check_outputs(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (exp_q.size() == 0) break;
      read_key($sformatf("%s_rd%0d", tag, i));
    end
    check({tag, "_empty"}, key_ready, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows0;
    rst = 1'b1; ps2_ready = 1'b0; ps2_data = 8'h00; key_rd = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_rdn", ps2_rdn, 1'b1);
    check_outputs("rst");
    check_mods("rst");
    rst = 1'b0;
    @(negedge clk);

    // Make/break of 'a': one entry, three single-cycle pops of mio_ps2
    lows0 = rdn_lows;
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    check("t1_rdn_pulses", rdn_lows - lows0, 3);
    check("t1_count", exp_q.size(), 1);
    check("t1_head", key_dout, 8'h61);
    drain("t1");

    // Shift held then released
    foreach (exp_q[i]) ;
    send_byte(8'h12); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h12); send_byte(8'h1C);
    check_mods("t2");
    read_key("t2_rd0");
    check("t2_second", key_dout, 8'h61);
    drain("t2");

    // Caps Lock with and without Shift; Caps does not affect digits
    send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58); send_byte(8'h1C);
    send_byte(8'h12); send_byte(8'h1C); send_byte(8'h16);
    check_mods("t3");
    check("t3_head", key_dout, 8'h41);
    drain("t3");
    send_byte(8'hF0); send_byte(8'h12); send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
    check_mods("t3_clean");

    // Extended arrows: make pushes, break and unknown extended codes do not
    send_byte(8'hE0); send_byte(8'h75); send_byte(8'hE0); send_byte(8'hF0);
    send_byte(8'h75); send_byte(8'hE0); send_byte(8'h11);
    check_mods("t4");
    check("t4_count", exp_q.size(), 1);
    drain("t4");

    // Fill past capacity, then push with a simultaneous pop while full
    for (int i = 0; i < 9; i++) send_byte(letter_codes[i]);
    check("t5_ovf", key_overflow, 1'b1);
    check("t5_head", key_dout, 8'h61);
    send_byte(letter_codes[9], 1'b1);
    check("t5_head_adv", key_dout, 8'h62);
    check("t5_count", exp_q.size(), DEPTH);
    drain("t5");

    // Reset mid-prefix discards the pending break
    send_byte(8'h1C);
    send_byte(8'hF0);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    check("t6_rdn_during", ps2_rdn, 1'b1);
    check_outputs("t6_during");
    rst = 1'b0;
    @(negedge clk);
    check("t6_rdn_after", ps2_rdn, 1'b1);
    check_outputs("t6_after");
    check_mods("t6_after");
    send_byte(8'h1C);
    check("t6_fresh", key_dout, 8'h61);
    drain("t6");

    // Randomized key stream with random polling
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 18)      b = 8'hF0;
      else if (r < 26) b = 8'hE0;
      else if (r < 34) b = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
      else if (r < 38) b = 8'h58;
      else if (r < 68) b = letter_codes[$urandom_range(0, 25)];
      else if (r < 82) b = digit_codes[$urandom_range(0, 9)];
      else             b = misc_pool[$urandom_range(0, 15)];
      send_byte(b, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) read_key($sformatf("rnd_rd%0d", n));
      if (n % 50 == 49) check_mods($sformatf("rnd%0d", n));
    end
    drain("rnd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
